trng_collector: RTL

Digital back end of the TRNG. Receives the free-running raw bit from an entropy cell, synchronizes it and samples it at a programmable rate. Von Neumann debiasing (bypassable) is applied, and debiased bits are packed MSB-first into bytes offered on a valid/ready port. A repetition-count health test on the raw samples latches a sticky fault that blocks all output until reset.

---
 rtl/trng_collector_if.sv | 10 +
 rtl/trng_collector.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/trng_collector_if.sv
// Byte output port of the TRNG collector: valid/ready data plus the sticky fault flag.
interface trng_collector_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       rd_ready;
    logic       fault;

    modport master (output data_out, output data_valid, output fault, input rd_ready);
    modport slave  (input data_out, input data_valid, input fault, output rd_ready);
endinterface

// File: rtl/trng_collector.sv
// TRNG back end: synchronize and decimate the raw entropy bit, optionally Von Neumann
// debias it, pack MSB-first into bytes and guard the stream with a repetition-count test.
module trng_collector #(
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             raw_in,
    input  logic             vn_bypass,
    trng_collector_if.master rd
);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef struct packed {
        logic vld;
        logic b;
    } emit_t;

    typedef enum logic {VN_EMPTY, VN_HELD} vn_state_t;

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          strobe;

    vn_state_t     vn_state, vn_next;
    logic          vn_first;
    emit_t         emit;

    logic [RW-1:0] run, run_nxt;
    logic          prev;
    logic          fault_q;

    logic [7:0]    pk, pk_shift, byte_nxt;
    logic [3:0]    bcnt;
    logic          pk_full, out_free, load;
    logic [7:0]    data_q;
    logic          valid_q;

    // Two-flop synchronizer; only s2 is ever sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ena)
            cnt <= '0;
        else if (cnt == CW'(SAMPLE_DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign strobe = ena && (cnt == CW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vn_state <= VN_EMPTY;
            vn_first <= 1'b0;
        end else begin
            vn_state <= vn_next;
            if (strobe && !vn_bypass && vn_state == VN_EMPTY)
                vn_first <= s2;
        end
    end

    // A bypass strobe also drops any half pair, so toggling the mode never mixes regimes.
    always_comb begin
        vn_next = vn_state;
        emit    = '0;
        if (!ena) begin
            vn_next = VN_EMPTY;
        end else if (strobe) begin
            if (vn_bypass) begin
                vn_next  = VN_EMPTY;
                emit.vld = 1'b1;
                emit.b   = s2;
            end else if (vn_state == VN_EMPTY) begin
                vn_next = VN_HELD;
            end else begin
                vn_next  = VN_EMPTY;
                emit.vld = (vn_first != s2);
                emit.b   = vn_first;
            end
        end
    end

    always_comb begin
        run_nxt = RW'(1);
        if (run != '0 && s2 == prev)
            run_nxt = (run == RW'(REP_LIMIT)) ? run : run + RW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run     <= '0;
            prev    <= 1'b0;
            fault_q <= 1'b0;
        end else if (!ena) begin
            run <= '0;
        end else if (strobe) begin
            run  <= run_nxt;
            prev <= s2;
            if (run_nxt == RW'(REP_LIMIT))
                fault_q <= 1'b1;
        end
    end

    // A full packer waits for the output register; bits arriving meanwhile are lost.
    assign pk_shift = {pk[6:0], emit.b};
    assign pk_full  = (bcnt == 4'd8);
    assign out_free = !valid_q || rd.rd_ready;
    assign byte_nxt = pk_full ? pk : pk_shift;
    assign load     = !fault_q && out_free && (pk_full || (emit.vld && bcnt == 4'd7));

    always_ff @(posedge clk) begin
        if (!rst_n || fault_q || load) begin
            pk   <= '0;
            bcnt <= '0;
        end else if (emit.vld && !pk_full) begin
            pk   <= pk_shift;
            bcnt <= bcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (fault_q) begin
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= byte_nxt;
            valid_q <= 1'b1;
        end else if (valid_q && rd.rd_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rd.data_out   = data_q;
    assign rd.data_valid = valid_q;
    assign rd.fault      = fault_q;
endmodule
